// File: rtl/key_hold_pkg.sv
`default_nettype none
// ============================================================================
// Module   : key_hold_pkg
// Purpose  : Shared definitions for the key_hold block: per-channel FSM state
//            encoding, default hold/repeat timing and the counter-width helper.
// Revision : 1.0 - initial release
// ============================================================================
package key_hold_pkg;

  // Per-channel autorepeat states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    REPEAT = 2'd2
  } state_t;

  // Default timing: 0.65 s to first repeat, 0.13 s between repeats at 50 MHz
  localparam int c_HOLD_CYCLES_DEF   = 32_500_000;
  localparam int c_REPEAT_CYCLES_DEF = 6_500_000;

  // Counter width wide enough for the larger of the two terminal counts
  function automatic int cnt_width(input int hold_cycles, input int repeat_cycles);
    return $clog2((hold_cycles > repeat_cycles) ? hold_cycles : repeat_cycles);
  endfunction

endpackage : key_hold_pkg
`default_nettype wire

// File: rtl/key_hold_if.sv
`default_nettype none
// ============================================================================
// Module   : key_hold_if
// Purpose  : Bundle of the key_hold data signals.
// Ports    : master - drives keycode/move, observes the conditioned outputs
//            slave  - the key_hold block itself
//            keycode/move in; keycode_ff, key_new, move_ff, press, rel,
//            rpt, held out. 'rel' is the release pulse ('release' is a
//            reserved word).
// Revision : 1.0 - initial release
// ============================================================================
interface key_hold_if #(
  parameter int CH    = 4,
  parameter int KEY_W = 16
) ();

  logic [KEY_W-1:0] keycode;
  logic [CH-1:0]    move;
  logic [KEY_W-1:0] keycode_ff;
  logic             key_new;
  logic [CH-1:0]    move_ff;
  logic [CH-1:0]    press;
  logic [CH-1:0]    rel;
  logic [CH-1:0]    rpt;
  logic [CH-1:0]    held;

  modport master (
    output keycode, move,
    input  keycode_ff, key_new, move_ff, press, rel, rpt, held
  );

  modport slave (
    input  keycode, move,
    output keycode_ff, key_new, move_ff, press, rel, rpt, held
  );

endinterface : key_hold_if
`default_nettype wire

// File: rtl/key_hold_chan.sv
`default_nettype none
// ============================================================================
// Module   : key_hold_chan
// Purpose  : One move channel: registered level, press/release edge pulses
//            and (with KEY_HOLD_REPEAT_EN) the hold/autorepeat FSM.
// Ports    : clk, rst (sync, active-low), move (raw level),
//            move_ff, press, rel, rpt, held (all registered)
// Config   : KEY_HOLD_REPEAT_EN - enables the FSM/counter; otherwise rpt and
//            held are tied to 0.
// Revision : 1.0 - initial release
// ============================================================================
module key_hold_chan
  import key_hold_pkg::*;
#(
`ifdef KEY_HOLD_REPEAT_EN
  parameter int HOLD_CYCLES   = c_HOLD_CYCLES_DEF,
  parameter int REPEAT_CYCLES = c_REPEAT_CYCLES_DEF
`endif
) (
  input  wire  clk,
  input  wire  rst,
  input  wire  move,
  output logic move_ff,
  output logic press,
  output logic rel,
  output logic rpt,
  output logic held
);

  logic r_move_ff;
  logic r_press;
  logic r_rel;

  // Edge pulses are computed against the previous level so that they line up
  // with the move_ff transition.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_move_ff <= 1'b0;
      r_press   <= 1'b0;
      r_rel     <= 1'b0;
    end else begin
      r_move_ff <= move;
      r_press   <= move & ~r_move_ff;
      r_rel     <= ~move & r_move_ff;
    end
  end

  assign move_ff = r_move_ff;
  assign press   = r_press;
  assign rel     = r_rel;

`ifdef KEY_HOLD_REPEAT_EN
  localparam int CW = cnt_width(HOLD_CYCLES, REPEAT_CYCLES);
  localparam logic [CW-1:0] c_HOLD_LAST   = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] c_REPEAT_LAST = CW'(REPEAT_CYCLES - 1);

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_rpt;
  logic          r_held;

  // The FSM follows the raw move level, so it enters WAIT on the same edge
  // that registers the press pulse; the first rpt therefore lands exactly
  // HOLD_CYCLES cycles after the press cycle. Counters are cleared on their
  // terminal value and so never wrap.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_rpt   <= 1'b0;
      r_held  <= 1'b0;
    end else begin
      r_rpt <= 1'b0;
      if (!move) begin
        // Release wins over any repeat due on this edge
        r_state <= IDLE;
        r_cnt   <= '0;
        r_held  <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            r_state <= WAIT;
            r_cnt   <= '0;
            r_held  <= 1'b0;
          end
          WAIT: begin
            if (r_cnt == c_HOLD_LAST) begin
              r_state <= REPEAT;
              r_cnt   <= '0;
              r_rpt   <= 1'b1;
              r_held  <= 1'b1;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          REPEAT: begin
            r_held <= 1'b1;
            if (r_cnt == c_REPEAT_LAST) begin
              r_cnt <= '0;
              r_rpt <= 1'b1;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          default: begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_held  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign rpt  = r_rpt;
  assign held = r_held;
`else
  assign rpt  = 1'b0;
  assign held = 1'b0;
`endif

endmodule : key_hold_chan
`default_nettype wire

// File: rtl/key_hold.sv
`default_nettype none
// ============================================================================
// Module   : key_hold
// Purpose  : Keyboard input conditioning: registers the keycode with a
//            change pulse and runs CH independent move channels producing
//            press/release pulses and optional hold-to-autorepeat.
// Ports    : clk  - sole clock
//            rst  - synchronous, active-low reset
//            bus  - key_hold_if.slave (keycode, move in; keycode_ff, key_new,
//                   move_ff, press, rel, rpt, held out)
// Config   : KEY_HOLD_REPEAT_EN - when undefined no FSMs/counters are built
//            and rpt/held are constant 0.
// Revision : 1.0 - initial release
// ============================================================================
module key_hold
  import key_hold_pkg::*;
#(
  parameter int CH            = 4,
  parameter int KEY_W         = 16,
  parameter int HOLD_CYCLES   = c_HOLD_CYCLES_DEF,
  parameter int REPEAT_CYCLES = c_REPEAT_CYCLES_DEF
) (
  input  wire         clk,
  input  wire         rst,
  key_hold_if.slave   bus
);

  // Reject timing values the counter logic cannot honour
  if (HOLD_CYCLES < 2 || REPEAT_CYCLES < 1) begin : g_bad_cfg
    $error("key_hold: HOLD_CYCLES must be >= 2 and REPEAT_CYCLES >= 1");
  end

  logic [KEY_W-1:0] r_keycode_ff;
  logic             r_key_new;

  // key_new compares against the old registered value, so it is high in the
  // same cycle keycode_ff shows the new code.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_keycode_ff <= '0;
      r_key_new    <= 1'b0;
    end else begin
      r_keycode_ff <= bus.keycode;
      r_key_new    <= (bus.keycode != r_keycode_ff);
    end
  end

  assign bus.keycode_ff = r_keycode_ff;
  assign bus.key_new    = r_key_new;

  logic [CH-1:0] w_move_ff;
  logic [CH-1:0] w_press;
  logic [CH-1:0] w_rel;
  logic [CH-1:0] w_rpt;
  logic [CH-1:0] w_held;

  for (genvar i = 0; i < CH; i++) begin : g_chan
    key_hold_chan
`ifdef KEY_HOLD_REPEAT_EN
    #(
      .HOLD_CYCLES   (HOLD_CYCLES),
      .REPEAT_CYCLES (REPEAT_CYCLES)
    )
`endif
    u_chan (
      .clk     (clk),
      .rst     (rst),
      .move    (bus.move[i]),
      .move_ff (w_move_ff[i]),
      .press   (w_press[i]),
      .rel     (w_rel[i]),
      .rpt     (w_rpt[i]),
      .held    (w_held[i])
    );
  end

  assign bus.move_ff = w_move_ff;
  assign bus.press   = w_press;
  assign bus.rel     = w_rel;
  assign bus.rpt     = w_rpt;
  assign bus.held    = w_held;

endmodule : key_hold
`default_nettype wire

// File: tb/tb_key_hold.sv
`default_nettype none
// ============================================================================
// Module   : tb_key_hold
// Purpose  : Directed self-checking bench for key_hold with CH=4, KEY_W=16,
//            HOLD_CYCLES=4, REPEAT_CYCLES=2. Expected rpt/held follow the
//            KEY_HOLD_REPEAT_EN setting of the build.
// Revision : 1.0 - initial release
// ============================================================================
module tb_key_hold;

`ifdef KEY_HOLD_REPEAT_EN
  localparam bit c_REP = 1'b1;
`else
  localparam bit c_REP = 1'b0;
`endif

  logic clk;
  logic rst;

  int checks;
  int errors;

  key_hold_if #(.CH(4), .KEY_W(16)) bus ();

  key_hold #(
    .CH            (4),
    .KEY_W         (16),
    .HOLD_CYCLES   (4),
    .REPEAT_CYCLES (2)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle before sampling outputs
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_keycode_ff"}, 32'(bus.keycode_ff), 32'h0);
    chk({tag, "_key_new"},    32'(bus.key_new),    32'h0);
    chk({tag, "_move_ff"},    32'(bus.move_ff),    32'h0);
    chk({tag, "_press"},      32'(bus.press),      32'h0);
    chk({tag, "_rel"},        32'(bus.rel),        32'h0);
    chk({tag, "_rpt"},        32'(bus.rpt),        32'h0);
    chk({tag, "_held"},       32'(bus.held),       32'h0);
  endtask

  initial begin
    logic [3:0] m;
    logic [3:0] e_rel;
    logic [3:0] e_rpt;
    logic [3:0] e_held;

    checks = 0;
    errors = 0;

    // ---- Reset with inputs active: everything held at zero ----
    rst         = 1'b0;
    bus.move    = 4'b1111;
    bus.keycode = 16'hABCD;
    tick();
    tick();
    chk_all_zero("rst");

    // ---- First edge after reset ----
    rst = 1'b1;
    tick();
    chk("post_rst_press",      32'(bus.press),      32'hF);
    chk("post_rst_move_ff",    32'(bus.move_ff),    32'hF);
    chk("post_rst_key_new",    32'(bus.key_new),    32'h1);
    chk("post_rst_keycode_ff", 32'(bus.keycode_ff), 32'hABCD);
    chk("post_rst_rel",        32'(bus.rel),        32'h0);
    tick();
    chk("press_one_cycle",     32'(bus.press),      32'h0);
    chk("key_new_one_cycle",   32'(bus.key_new),    32'h0);

    // ---- Release all, then a keycode change ----
    bus.move    = 4'b0000;
    bus.keycode = 16'h1234;
    tick();
    chk("rel_all",             32'(bus.rel),        32'hF);
    chk("rel_all_move_ff",     32'(bus.move_ff),    32'h0);
    chk("kc_change_key_new",   32'(bus.key_new),    32'h1);
    chk("kc_change_value",     32'(bus.keycode_ff), 32'h1234);
    tick();
    chk("rel_one_cycle",       32'(bus.rel),        32'h0);
    chk("kc_steady_key_new",   32'(bus.key_new),    32'h0);
    chk("idle_rpt",            32'(bus.rpt),        32'h0);
    chk("idle_held",           32'(bus.held),       32'h0);

    // ---- Concurrent channels: ch0 12 cycles, ch1 3 cycles, ch2 4 cycles ----
    bus.move = 4'b0111;
    tick();   // cycle 0
    chk("c0_press",   32'(bus.press),   32'h7);
    chk("c0_move_ff", 32'(bus.move_ff), 32'h7);
    chk("c0_rpt",     32'(bus.rpt),     32'h0);
    chk("c0_held",    32'(bus.held),    32'h0);
    for (int c = 1; c <= 13; c++) begin
      m        = {1'b0, (c < 4), (c < 3), (c < 12)};
      bus.move = m;
      tick();
      e_rel  = {1'b0, (c == 4), (c == 3), (c == 12)};
      e_rpt  = c_REP ? {3'b000, (c >= 4 && c <= 10 && (c % 2) == 0)} : 4'b0000;
      e_held = c_REP ? {3'b000, (c >= 4 && c <= 11)} : 4'b0000;
      chk($sformatf("c%0d_move_ff", c), 32'(bus.move_ff), 32'(m));
      chk($sformatf("c%0d_press", c),   32'(bus.press),   32'h0);
      chk($sformatf("c%0d_rel", c),     32'(bus.rel),     32'(e_rel));
      chk($sformatf("c%0d_rpt", c),     32'(bus.rpt),     32'(e_rpt));
      chk($sformatf("c%0d_held", c),    32'(bus.held),    32'(e_held));
    end

    // ---- Reset mid-hold on ch3 with move kept high ----
    bus.move = 4'b1000;
    tick();   // cycle 0
    chk("r3_press", 32'(bus.press), 32'h8);
    for (int c = 1; c <= 4; c++) begin
      tick();
      chk($sformatf("r3_c%0d_rpt", c),  32'(bus.rpt),  (c_REP && c == 4) ? 32'h8 : 32'h0);
      chk($sformatf("r3_c%0d_held", c), 32'(bus.held), (c_REP && c == 4) ? 32'h8 : 32'h0);
    end
    rst = 1'b0;
    tick();   // cycle 5: reset edge
    chk_all_zero("r3_rst");
    rst = 1'b1;
    tick();   // cycle 6: fresh press
    chk("r3_repress",         32'(bus.press),      32'h8);
    chk("r3_repress_move_ff", 32'(bus.move_ff),    32'h8);
    chk("r3_repress_key_new", 32'(bus.key_new),    32'h1);
    chk("r3_repress_keycode", 32'(bus.keycode_ff), 32'h1234);
    for (int c = 7; c <= 11; c++) begin
      tick();
      chk($sformatf("r3_c%0d_rpt", c),  32'(bus.rpt),  (c_REP && c == 10) ? 32'h8 : 32'h0);
      chk($sformatf("r3_c%0d_held", c), 32'(bus.held), (c_REP && c >= 10) ? 32'h8 : 32'h0);
    end
    bus.move = 4'b0000;
    tick();
    chk("r3_rel",      32'(bus.rel),  32'h8);
    chk("r3_rel_rpt",  32'(bus.rpt),  32'h0);
    chk("r3_rel_held", 32'(bus.held), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_key_hold
`default_nettype wire
